// File: rtl/multicycle_controller_if.sv
// Control/handshake bundle between the multicycle controller (master) and the
// datapath plus instruction/data memories (slave).
interface multicycle_controller_if #(
  parameter int RET_W = 32
);
  logic [6:0]       Opcode;
  logic             instr_valid;
  logic             mem_ready;
  logic             instr_req;
  logic             IRWrite;
  logic             PCWrite;
  logic             ALUSrc;
  logic             MemtoReg;
  logic             RegWrite;
  logic             MemRead;
  logic             MemWrite;
  logic             Branch;
  logic [1:0]       ALUOp;
  logic [1:0]       RWseal;
  logic             illegal;
  logic             mem_timeout;
  logic [RET_W-1:0] retired;

  modport master (
    input  Opcode, instr_valid, mem_ready,
    output instr_req, IRWrite, PCWrite, ALUSrc, MemtoReg, RegWrite,
           MemRead, MemWrite, Branch, ALUOp, RWseal, illegal, mem_timeout,
           retired
  );

  modport slave (
    output Opcode, instr_valid, mem_ready,
    input  instr_req, IRWrite, PCWrite, ALUSrc, MemtoReg, RegWrite,
           MemRead, MemWrite, Branch, ALUOp, RWseal, illegal, mem_timeout,
           retired
  );
endinterface

// File: rtl/multicycle_controller.sv
// Multicycle RV32-style control FSM: FETCH/DECODE/EXEC/MEM/WB with a bounded
// memory wait. Optional HALT instruction (opcode 0001011) under `HALT_INSTR_EN.
module multicycle_controller #(
  parameter int MEM_TIMEOUT = 16,
  parameter int RET_W       = 32
) (
  input  logic                   clk,
  input  logic                   reset,
  multicycle_controller_if.master bus,
  output logic [2:0]             dbg_state
);

  // Handshakes: an instruction is taken in the cycle instr_req && instr_valid
  // are both high (Opcode sampled then); a data access holds MemRead/MemWrite
  // until the cycle mem_ready is high, which completes it.

  localparam logic [2:0] S_FETCH  = 3'd0;
  localparam logic [2:0] S_DECODE = 3'd1;
  localparam logic [2:0] S_EXEC   = 3'd2;
  localparam logic [2:0] S_MEM    = 3'd3;
  localparam logic [2:0] S_WB     = 3'd4;
`ifdef HALT_INSTR_EN
  localparam logic [2:0] S_HALT   = 3'd5;
  localparam logic [6:0] OP_HALT  = 7'b0001011;
`endif

  localparam logic [6:0] OP_R    = 7'b0110011;
  localparam logic [6:0] OP_I    = 7'b0010011;
  localparam logic [6:0] OP_LOAD = 7'b0000011;
  localparam logic [6:0] OP_S    = 7'b0100011;
  localparam logic [6:0] OP_B    = 7'b1100011;
  localparam logic [6:0] OP_JAL  = 7'b1101111;
  localparam logic [6:0] OP_JALR = 7'b1100111;
  localparam logic [6:0] OP_LUI  = 7'b0110111;

  localparam logic [7:0] WAIT_LAST = 8'(MEM_TIMEOUT - 1);

  logic [2:0]       state, state_nxt;
  logic [6:0]       op_q;
  logic [7:0]       wait_cnt;
  logic [RET_W-1:0] ret_cnt;
  logic             retire;

  logic is_r, is_i, is_load, is_s, is_b, is_jal, is_jalr, is_lui, is_halt, is_legal;

  assign is_r    = (op_q == OP_R);
  assign is_i    = (op_q == OP_I);
  assign is_load = (op_q == OP_LOAD);
  assign is_s    = (op_q == OP_S);
  assign is_b    = (op_q == OP_B);
  assign is_jal  = (op_q == OP_JAL);
  assign is_jalr = (op_q == OP_JALR);
  assign is_lui  = (op_q == OP_LUI);
`ifdef HALT_INSTR_EN
  assign is_halt = (op_q == OP_HALT);
`else
  assign is_halt = 1'b0;
`endif
  assign is_legal = is_r | is_i | is_load | is_s | is_b | is_jal | is_jalr | is_lui | is_halt;

  always_comb begin
    state_nxt       = state;
    retire          = 1'b0;
    bus.instr_req   = 1'b0;
    bus.IRWrite     = 1'b0;
    bus.PCWrite     = 1'b0;
    bus.ALUSrc      = 1'b0;
    bus.MemtoReg    = 1'b0;
    bus.RegWrite    = 1'b0;
    bus.MemRead     = 1'b0;
    bus.MemWrite    = 1'b0;
    bus.Branch      = 1'b0;
    bus.ALUOp       = 2'b00;
    bus.RWseal      = 2'b00;
    bus.illegal     = 1'b0;
    bus.mem_timeout = 1'b0;
    case (state)
      S_FETCH: begin
        bus.instr_req = 1'b1;
        if (bus.instr_valid) begin
          bus.IRWrite = 1'b1;
          state_nxt   = S_DECODE;
        end
      end
      S_DECODE: begin
        if (!is_legal) begin
          bus.illegal = 1'b1;
          state_nxt   = S_FETCH;
`ifdef HALT_INSTR_EN
        end else if (is_halt) begin
          retire    = 1'b1;
          state_nxt = S_HALT;
`endif
        end else begin
          state_nxt = S_EXEC;
        end
      end
      S_EXEC: begin
        bus.ALUOp  = is_b ? 2'b01 : ((is_r | is_i) ? 2'b10 : 2'b00);
        bus.ALUSrc = is_i | is_load | is_s | is_jalr;
        if (is_b) begin
          bus.Branch  = 1'b1;
          bus.PCWrite = 1'b1;
          retire      = 1'b1;
          state_nxt   = S_FETCH;
        end else if (is_load | is_s) begin
          state_nxt = S_MEM;
        end else begin
          state_nxt = S_WB;
        end
      end
      S_MEM: begin
        bus.MemRead  = is_load;
        bus.MemWrite = is_s;
        // A ready on the final allowed cycle still completes the access.
        if (bus.mem_ready) begin
          if (is_load) begin
            state_nxt = S_WB;
          end else begin
            bus.PCWrite = 1'b1;
            retire      = 1'b1;
            state_nxt   = S_FETCH;
          end
        end else if (wait_cnt == WAIT_LAST) begin
          bus.mem_timeout = 1'b1;
          state_nxt       = S_FETCH;
        end
      end
      S_WB: begin
        bus.RegWrite = 1'b1;
        bus.PCWrite  = 1'b1;
        bus.MemtoReg = is_load;
        bus.Branch   = is_jal;
        bus.RWseal   = (is_jal | is_jalr) ? 2'b01 : (is_lui ? 2'b10 : 2'b00);
        retire       = 1'b1;
        state_nxt    = S_FETCH;
      end
`ifdef HALT_INSTR_EN
      S_HALT: state_nxt = S_HALT;
`endif
      default: state_nxt = S_FETCH;
    endcase

    // While reset is held the outputs look like an idle FETCH.
    if (reset) begin
      retire          = 1'b0;
      bus.instr_req   = 1'b1;
      bus.IRWrite     = 1'b0;
      bus.PCWrite     = 1'b0;
      bus.ALUSrc      = 1'b0;
      bus.MemtoReg    = 1'b0;
      bus.RegWrite    = 1'b0;
      bus.MemRead     = 1'b0;
      bus.MemWrite    = 1'b0;
      bus.Branch      = 1'b0;
      bus.ALUOp       = 2'b00;
      bus.RWseal      = 2'b00;
      bus.illegal     = 1'b0;
      bus.mem_timeout = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= S_FETCH;
      op_q     <= 7'd0;
      wait_cnt <= 8'd0;
      ret_cnt  <= '0;
    end else begin
      state <= state_nxt;
      if (state == S_FETCH && bus.instr_valid) op_q <= bus.Opcode;
      // Counter only runs inside MEM, so it is zero on every MEM entry.
      if (state == S_MEM) wait_cnt <= wait_cnt + 8'd1;
      else                wait_cnt <= 8'd0;
      if (retire) ret_cnt <= ret_cnt + 1'b1;
    end
  end

  assign bus.retired = ret_cnt;
  assign dbg_state   = state;

endmodule

// File: tb/tb_multicycle_controller.sv
// Directed bench for multicycle_controller: per-cycle expected control vectors
// are generated from an instruction-level model into a queue and checked.
module tb_multicycle_controller;
  localparam int MEM_TO = 4;
  localparam int RW     = 4;
  localparam int VW     = 15;

  localparam logic [6:0] OP_R    = 7'b0110011;
  localparam logic [6:0] OP_I    = 7'b0010011;
  localparam logic [6:0] OP_LOAD = 7'b0000011;
  localparam logic [6:0] OP_S    = 7'b0100011;
  localparam logic [6:0] OP_B    = 7'b1100011;
  localparam logic [6:0] OP_JAL  = 7'b1101111;
  localparam logic [6:0] OP_JALR = 7'b1100111;
  localparam logic [6:0] OP_LUI  = 7'b0110111;
  localparam logic [6:0] OP_HALT = 7'b0001011;
  localparam logic [6:0] OP_BAD  = 7'b1111111;

  // Vector layout: {instr_req, IRWrite, PCWrite, ALUSrc, MemtoReg, RegWrite,
  //                 MemRead, MemWrite, Branch, ALUOp[1:0], RWseal[1:0], illegal, mem_timeout}
  localparam logic [VW-1:0] V_REQ = 15'h4000;
  localparam logic [VW-1:0] V_IRW = 15'h2000;
  localparam logic [VW-1:0] V_PCW = 15'h1000;
  localparam logic [VW-1:0] V_SRC = 15'h0800;
  localparam logic [VW-1:0] V_M2R = 15'h0400;
  localparam logic [VW-1:0] V_RGW = 15'h0200;
  localparam logic [VW-1:0] V_MRD = 15'h0100;
  localparam logic [VW-1:0] V_MWR = 15'h0080;
  localparam logic [VW-1:0] V_BR  = 15'h0040;
  localparam logic [VW-1:0] V_ILL = 15'h0002;
  localparam logic [VW-1:0] V_MTO = 15'h0001;

  localparam logic [2:0] ST_FETCH = 3'd0;

  logic       clk = 1'b0;
  logic       reset;
  logic [2:0] dbg_state;

  multicycle_controller_if #(.RET_W(RW)) bus();

  multicycle_controller #(.MEM_TIMEOUT(MEM_TO), .RET_W(RW)) dut (
    .clk       (clk),
    .reset     (reset),
    .bus       (bus),
    .dbg_state (dbg_state)
  );

  always #5 clk = ~clk;

  logic [VW-1:0] obs;
  assign obs = {bus.instr_req, bus.IRWrite, bus.PCWrite, bus.ALUSrc, bus.MemtoReg,
                bus.RegWrite, bus.MemRead, bus.MemWrite, bus.Branch, bus.ALUOp,
                bus.RWseal, bus.illegal, bus.mem_timeout};

  logic [VW-1:0] exp_q[$];
  int            n_tests = 0;
  int            n_fail  = 0;
  logic [RW-1:0] ret_exp;

  task automatic check(input string tag, input logic [31:0] o, input logic [31:0] e);
    n_tests++;
    assert (o === e) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, o, e);
    end
  endtask

  function automatic logic is_legal(input logic [6:0] opc);
    case (opc)
      OP_R, OP_I, OP_LOAD, OP_S, OP_B, OP_JAL, OP_JALR, OP_LUI: return 1'b1;
`ifdef HALT_INSTR_EN
      OP_HALT: return 1'b1;
`endif
      default: return 1'b0;
    endcase
  endfunction

  // One clock: drive inputs, compare at the falling edge, advance past the rising edge.
  task automatic step(input logic v, input logic [6:0] opc, input logic rdy,
                      input logic rst, input string tag);
    logic [VW-1:0] e;
    bus.instr_valid = v;
    bus.Opcode      = opc;
    bus.mem_ready   = rdy;
    reset           = rst;
    @(negedge clk);
    e = exp_q.pop_front();
    check(tag, 32'(obs), 32'(e));
    @(posedge clk);
    #1;
  endtask

  // Instruction-level model: expected vector for every cycle of one instruction.
  task automatic push_instr(input logic [6:0] opc, input int stall, input int ready_at,
                            output logic retires);
    logic [VW-1:0] e, mem;
    retires = 1'b0;
    for (int s = 0; s < stall; s++) exp_q.push_back(V_REQ);
    exp_q.push_back(V_REQ | V_IRW);
    if (!is_legal(opc)) begin
      exp_q.push_back(V_ILL);
      return;
    end
    exp_q.push_back('0);
`ifdef HALT_INSTR_EN
    if (opc == OP_HALT) begin
      retires = 1'b1;
      for (int h = 0; h < 20; h++) exp_q.push_back('0);
      return;
    end
`endif
    e = '0;
    if (opc == OP_B) e = e | (15'd1 << 4);
    if (opc == OP_R || opc == OP_I) e = e | (15'd2 << 4);
    if (opc == OP_I || opc == OP_LOAD || opc == OP_S || opc == OP_JALR) e = e | V_SRC;
    if (opc == OP_B) begin
      exp_q.push_back(e | V_PCW | V_BR);
      retires = 1'b1;
      return;
    end
    exp_q.push_back(e);
    if (opc == OP_LOAD || opc == OP_S) begin
      mem = (opc == OP_LOAD) ? V_MRD : V_MWR;
      for (int k = 1; k <= MEM_TO; k++) begin
        if (k == ready_at) begin
          if (opc == OP_S) begin
            exp_q.push_back(mem | V_PCW);
            retires = 1'b1;
            return;
          end
          exp_q.push_back(mem);
          break;
        end else if (k == MEM_TO) begin
          exp_q.push_back(mem | V_MTO);
          return;
        end
        exp_q.push_back(mem);
      end
    end
    e = V_RGW | V_PCW;
    if (opc == OP_LOAD) e = e | V_M2R;
    if (opc == OP_JAL) e = e | V_BR;
    if (opc == OP_JAL || opc == OP_JALR) e = e | (15'd1 << 2);
    if (opc == OP_LUI) e = e | (15'd2 << 2);
    exp_q.push_back(e);
    retires = 1'b1;
  endtask

  // Drives one instruction; Opcode carries junk outside the fetch handshake.
  task automatic run_instr(input logic [6:0] opc, input int stall, input int ready_at,
                           input string tag);
    logic ret, v, r;
    int   n;
    push_instr(opc, stall, ready_at, ret);
    n = exp_q.size();
    for (int c = 0; c < n; c++) begin
      v = (c == stall);
      r = (ready_at > 0) && (c == stall + 2 + ready_at);
      step(v, v ? opc : 7'($urandom_range(0, 127)), r, 1'b0, tag);
    end
    if (ret) ret_exp = ret_exp + 1'b1;
    check({tag, " retired"}, 32'(bus.retired), 32'(ret_exp));
  endtask

  initial begin
    logic [6:0] pool[6];
    pool[0] = OP_R; pool[1] = OP_I; pool[2] = OP_LUI;
    pool[3] = OP_JAL; pool[4] = OP_JALR; pool[5] = OP_B;
    ret_exp = '0;
    bus.instr_valid = 1'b0;
    bus.Opcode      = 7'd0;
    bus.mem_ready   = 1'b0;
    reset           = 1'b1;
    @(posedge clk);
    #1;

    // Reset held with a valid instruction offered: FETCH-like, no IRWrite.
    exp_q.push_back(V_REQ);
    exp_q.push_back(V_REQ);
    step(1'b1, OP_R, 1'b1, 1'b1, "reset_hold");
    step(1'b1, OP_R, 1'b1, 1'b1, "reset_hold");
    check("reset retired", 32'(bus.retired), 32'(ret_exp));
    check("reset state", 32'(dbg_state), 32'(ST_FETCH));

    // First fetch accepted right after reset, then each opcode class.
    run_instr(OP_R,    0, 0, "r_type");
    run_instr(OP_I,    $urandom_range(0, 2), 0, "i_type");
    run_instr(OP_LUI,  $urandom_range(0, 2), 0, "lui");
    run_instr(OP_JAL,  $urandom_range(0, 2), 0, "jal");
    run_instr(OP_JALR, $urandom_range(0, 2), 0, "jalr");
    run_instr(OP_B,    0, 0, "branch");
    run_instr(OP_BAD,  0, 0, "illegal");

    // Memory paths: waits, completion on the final cycle, timeouts.
    run_instr(OP_LOAD, 0, 3, "load_w2");
    run_instr(OP_S,    0, 0, "store_timeout");
    check("timeout state", 32'(dbg_state), 32'(ST_FETCH));
    run_instr(OP_LOAD, 1, 0, "load_timeout");
    run_instr(OP_S,    0, 1, "store_w0");
    run_instr(OP_LOAD, 0, MEM_TO, "load_ready_last");
    run_instr(OP_S,    2, MEM_TO, "store_ready_last");
    run_instr(OP_LOAD, 0, 1, "load_w0");

    // Enough retirements to wrap the narrow retired counter.
    for (int i = 0; i < 18; i++)
      run_instr(pool[$urandom_range(0, 5)], $urandom_range(0, 1), 0, "wrap_mix");

    // Reset during the second MEM wait cycle of a load.
    exp_q.push_back(V_REQ | V_IRW);
    exp_q.push_back('0);
    exp_q.push_back(V_SRC);
    exp_q.push_back(V_MRD);
    exp_q.push_back(V_REQ);
    exp_q.push_back(V_REQ);
    step(1'b1, OP_LOAD, 1'b0, 1'b0, "mid_mem fetch");
    step(1'b0, 7'd0,    1'b0, 1'b0, "mid_mem decode");
    step(1'b0, 7'd0,    1'b0, 1'b0, "mid_mem exec");
    step(1'b0, 7'd0,    1'b0, 1'b0, "mid_mem mem1");
    step(1'b0, 7'd0,    1'b0, 1'b1, "mid_mem reset");
    ret_exp = '0;
    step(1'b0, 7'd0,    1'b0, 1'b0, "mid_mem after");
    check("mid_mem retired", 32'(bus.retired), 32'(ret_exp));
    check("mid_mem state", 32'(dbg_state), 32'(ST_FETCH));

    run_instr(OP_R, 0, 0, "post_reset_r");

    // 0001011: HALT when enabled, otherwise illegal.
    run_instr(OP_HALT, 0, 0, "halt_op");
    exp_q.push_back(V_REQ);
    step(1'b0, 7'd0, 1'b0, 1'b1, "halt_exit_reset");
    ret_exp = '0;
    run_instr(OP_I, 0, 0, "after_halt");

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
